// File: rtl/timer_dev_pkg.sv
// Shared definitions for the timer_dev countdown timer: FSM states,
// register offsets, CTRL bit positions and MODE encodings.
package timer_dev_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    // Word offsets on the 2-bit address bus
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    // CTRL bit positions (MODE occupies MODE+1:MODE)
    localparam int EN   = 0;
    localparam int MODE = 1;
    localparam int IM   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Only 01 selects auto-reload; 10 and 11 fall back to one-shot
    function automatic logic is_reload(input logic [3:0] ctrl);
        return ctrl[MODE +: 2] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a four-state
// countdown FSM and a maskable interrupt (level in one-shot, pulse in reload).
module timer_dev
    import timer_dev_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;
    logic        wr_ctrl, wr_preset;

    assign wr_ctrl   = we && (addr == TC_CTRL);
    assign wr_preset = we && (addr == TC_PRESET);

    // Next-state and register update: FSM effects first, core writes override
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[EN]) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[EN]) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Expiry at 1 or 0: never decrement past zero
                    count_d   = 32'd0;
                    pending_d = 1'b1;
                    state_d   = S_INT;
                end
            end
            S_INT: begin
                if (is_reload(ctrl_q)) begin
                    pending_d = 1'b0;
                    state_d   = S_LOAD;
                end else begin
                    ctrl_d[EN] = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A core write to CTRL wins over the FSM clearing EN in the same edge
        if (wr_ctrl)   ctrl_d   = wdata[3:0];
        if (wr_preset) preset_d = wdata;
        // Write-clear of pending has priority over expiry setting it
        if (wr_ctrl || wr_preset) pending_d = 1'b0;
    end

    // State and register file, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ctrl_q    <= 4'd0;
            preset_q  <= 32'd0;
            count_q   <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // Combinational register read; reserved offset reads zero
    always_comb begin
        rdata = 32'd0;
        case (addr)
            TC_CTRL:   rdata = {28'd0, ctrl_q};
            TC_PRESET: rdata = preset_q;
            TC_COUNT:  rdata = count_q;
            default:   rdata = 32'd0;
        endcase
    end

    assign irq = pending_q & ctrl_q[IM];

endmodule
